// File: rtl/array_mul3_bip.sv
// Registered unsigned array multiplier: WIDTH x WIDTH -> 2*WIDTH product.
// AND-array partial products, carry-save rows of full/half adders, final ripple merge.
module array_mul3_bip #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    output logic [2*WIDTH-1:0]   prod
);

    // Returns {carry, sum}; with cin tied low this is a half adder.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic cin);
        full_add = {(x & y) | (x & cin) | (y & cin), x ^ y ^ cin};
    endfunction

    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               vld_p1_q;
    logic [2*WIDTH-1:0] prod_q;
    logic               vld_p2_q;

    logic [WIDTH-1:0]   pp    [WIDTH];
    logic [WIDTH:0]     s_row [WIDTH];
    logic [WIDTH-1:0]   c_row [WIDTH];
    logic [2*WIDTH-1:0] prod_d;
    logic [1:0]         fa_out;
    logic               rc;

    // Stage 1 -> stage 2: combinational array on the registered operands.
    // Cell (i,j) sits at weight i+j; its sum feeds row i+1 one column to the
    // left-shifted position and its carry feeds row i+1 at the same column.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            pp[i]    = a_q & {WIDTH{b_q[i]}};
            s_row[i] = '0;
            c_row[i] = '0;
        end
        prod_d    = '0;
        fa_out    = '0;
        s_row[0]  = {1'b0, pp[0]};
        prod_d[0] = s_row[0][0];
        for (int i = 1; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                fa_out         = full_add(pp[i][j], s_row[i-1][j+1], c_row[i-1][j]);
                s_row[i][j]    = fa_out[0];
                c_row[i][j]    = fa_out[1];
            end
            prod_d[i] = s_row[i][0];
        end
        // Merge the leftover sum and carry rows; the final carry out is always zero.
        rc = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            fa_out            = full_add(s_row[WIDTH-1][k+1], c_row[WIDTH-1][k], rc);
            prod_d[WIDTH+k]   = fa_out[0];
            rc                = fa_out[1];
        end
    end

    // Stage 1: operand capture (held while idle to avoid array toggling).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            vld_p1_q <= 1'b0;
        end else begin
            if (in_valid) begin
                a_q <= a;
                b_q <= b;
            end
            vld_p1_q <= in_valid;
        end
    end

    // Stage 2: product register, holds its last value across bubbles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod_q   <= '0;
            vld_p2_q <= 1'b0;
        end else begin
            if (vld_p1_q) begin
                prod_q <= prod_d;
            end
            vld_p2_q <= vld_p1_q;
        end
    end

    assign prod      = prod_q;
    assign out_valid = vld_p2_q;

endmodule

// File: tb/tb_array_mul3_bip.sv
// Self-checking bench for array_mul3_bip (WIDTH=16): directed table, sweeps,
// bubbles, resets and random traffic checked through a due-cycle scoreboard.
module tb_array_mul3_bip;

    localparam int W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b1;
    logic [W-1:0]     a = 16'd5;
    logic [W-1:0]     b = 16'd7;
    logic             out_valid;
    logic [2*W-1:0]   prod;

    array_mul3_bip #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(out_valid), .prod(prod)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] exp;
        int             due;
    } sb_t;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
    } vec_t;

    sb_t            sbq[$];
    int             cyc = 0;
    int             checks = 0;
    int             passes = 0;
    logic [2*W-1:0] exp_hold = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    endtask

    // Every cycle: either the head of the scoreboard is due now, or the output
    // must be idle and holding the last delivered product.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                chk("out_valid", {63'b0, out_valid}, 64'd1);
                chk("prod", {32'b0, prod}, {32'b0, sbq[0].exp});
                exp_hold = sbq[0].exp;
                void'(sbq.pop_front());
            end else begin
                chk("idle_valid", {63'b0, out_valid}, 64'd0);
                chk("hold_prod", {32'b0, prod}, {32'b0, exp_hold});
            end
        end
    end

    task automatic drive(input logic rst, input logic v, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic [2*W-1:0] ev);
        @(negedge clk);
        #1;
        rst_n    = rst;
        in_valid = v;
        a        = av;
        b        = bv;
        if (!rst) begin
            sbq.delete();
            exp_hold = '0;
        end else if (v) begin
            sbq.push_back('{exp: ev, due: cyc + 2});
        end
    endtask

    vec_t vecs[8];
    logic [W-1:0] ra, rb;

    initial begin
        vecs[0] = '{a: 16'd3,     b: 16'd5,     exp: 32'd15};
        vecs[1] = '{a: 16'd255,   b: 16'd256,   exp: 32'd65280};
        vecs[2] = '{a: 16'd1,     b: 16'd65535, exp: 32'd65535};
        vecs[3] = '{a: 16'd65535, b: 16'd65535, exp: 32'd4294836225};
        vecs[4] = '{a: 16'd0,     b: 16'd65535, exp: 32'd0};
        vecs[5] = '{a: 16'd65535, b: 16'd1,     exp: 32'd65535};
        vecs[6] = '{a: 16'd256,   b: 16'd256,   exp: 32'd65536};
        vecs[7] = '{a: 16'd40000, b: 16'd3,     exp: 32'd120000};

        // Reset held with live inputs, then release with 5*7.
        drive(1'b0, 1'b1, 16'd5, 16'd7, 32'd0);
        drive(1'b0, 1'b1, 16'd5, 16'd7, 32'd0);
        drive(1'b1, 1'b1, 16'd5, 16'd7, 32'd35);
        drive(1'b1, 1'b0, 16'd0, 16'd0, 32'd0);
        drive(1'b1, 1'b0, 16'd0, 16'd0, 32'd0);

        // Counting sweep: a=0, b=0..63 back to back.
        for (int i = 0; i < 64; i++) drive(1'b1, 1'b1, 16'd0, W'(i), 32'd0);

        // Directed table, back to back.
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, vecs[i].a, vecs[i].b, vecs[i].exp);
        drive(1'b1, 1'b0, 16'd0, 16'd0, 32'd0);

        // Bubble: 10*10, idle with garbage operands, 12*12.
        drive(1'b1, 1'b1, 16'd10, 16'd10, 32'd100);
        drive(1'b1, 1'b0, 16'd999, 16'd777, 32'd0);
        drive(1'b1, 1'b1, 16'd12, 16'd12, 32'd144);
        drive(1'b1, 1'b0, 16'd0, 16'd0, 32'd0);
        drive(1'b1, 1'b0, 16'd0, 16'd0, 32'd0);

        // Reset one cycle after issuing 100*200: the result must never appear.
        drive(1'b1, 1'b1, 16'd100, 16'd200, 32'd20000);
        drive(1'b0, 1'b0, 16'd0, 16'd0, 32'd0);
        drive(1'b1, 1'b0, 16'd0, 16'd0, 32'd0);
        drive(1'b1, 1'b0, 16'd0, 16'd0, 32'd0);
        drive(1'b1, 1'b0, 16'd0, 16'd0, 32'd0);

        // Random back-to-back traffic.
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            drive(1'b1, 1'b1, ra, rb, 32'(ra) * 32'(rb));
        end

        // Drain with a bounded wait.
        for (int i = 0; i < 10 && sbq.size() > 0; i++) drive(1'b1, 1'b0, 16'd0, 16'd0, 32'd0);
        drive(1'b1, 1'b0, 16'd0, 16'd0, 32'd0);
        chk("drain", 64'(sbq.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
